// File: rtl/cordic_iter_if.sv
// Handshake and operand/result bus for the iterative CORDIC engine.
`timescale 1ns/1ps

interface cordic_iter_if #(
  parameter int unsigned W = 32
) ();

  logic                in_valid;
  logic                in_ready;
  logic                mode;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] z_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;
  logic signed [W-1:0] z_out;

  // Producer/consumer side of the engine
  modport master (
    output in_valid, mode, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out
  );

  // The CORDIC engine itself
  modport slave (
    input  in_valid, mode, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out
  );

endinterface

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or
// vectoring mode, valid/ready on both sides. Angles are binary angle units
// (2^(W-1) = pi). Optional output gain compensation is enabled by defining
// CORDIC_GAIN_COMP_EN (adds one multiply cycle before results are posted).
`timescale 1ns/1ps

module cordic_iter #(
  parameter int unsigned W    = 32,
  parameter int unsigned ITER = 16
) (
  input logic          clk,
  input logic          rst,
  cordic_iter_if.slave bus
);

  // Internal x/y carry two guard bits so the CORDIC gain cannot overflow
  localparam int unsigned XW = W + 2;
  localparam int unsigned IW = $clog2(ITER + 2);
  localparam int unsigned AW = $clog2(ITER);

`ifdef CORDIC_GAIN_COMP_EN
  // Counter value on the cycle that posts results (after the scale step)
  localparam int unsigned LAST = ITER + 1;
`else
  localparam int unsigned LAST = ITER;
`endif

  // Elaboration-time parameter range checks
  if (W < 12 || W > 32) begin : g_bad_w
    $error("cordic_iter: W out of range 12..32");
  end
  if (ITER < 4 || ITER > W - 2) begin : g_bad_iter
    $error("cordic_iter: ITER out of range 4..W-2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // round(atan(2^-k) * 2^(W-1) / pi), evaluated at elaboration only
  function automatic longint atan_val(input int k);
    real pi;
    real a;
    pi = 3.14159265358979323846;
    a  = $atan(2.0 ** (-k)) * (2.0 ** (W - 1)) / pi;
    return longint'(a);
  endfunction

  logic [W-1:0] atan_tab [ITER];

  // Arctangent constant table
  for (genvar g = 0; g < int'(ITER); g++) begin : g_atan
    localparam longint AV = atan_val(g);
    assign atan_tab[g] = W'(AV);
  end

  state_t               state;
  logic [IW-1:0]        i;
  logic                 mode_r;
  logic signed [XW-1:0] x_r;
  logic signed [XW-1:0] y_r;
  logic [W-1:0]         z_r;

  logic [AW-1:0]        ai;
  logic [W-1:0]         atan_i;
  logic                 d_pos;
  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic signed [XW-1:0] x_nx;
  logic signed [XW-1:0] y_nx;
  logic [W-1:0]         z_nx;

  assign ai = AW'(i);

  // One micro-rotation step for the current counter value
  always_comb begin
    x_sh   = x_r >>> i;
    y_sh   = y_r >>> i;
    atan_i = (i < IW'(ITER)) ? atan_tab[ai] : '0;
    d_pos  = mode_r ? y_r[XW-1] : ~z_r[W-1];
    if (d_pos) begin
      x_nx = x_r - y_sh;
      y_nx = y_r + x_sh;
      z_nx = z_r - atan_i;
    end else begin
      x_nx = x_r + y_sh;
      y_nx = y_r - x_sh;
      z_nx = z_r + atan_i;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int unsigned PW     = XW + W + 1;
  localparam longint      KINV_L = longint'(0.607252935 * (2.0 ** (W - 1)));
  // 1/K in Q(W-1); one extra bit keeps it positive as a signed operand
  localparam logic signed [W:0] KINV = (W + 1)'(KINV_L);

  logic signed [PW-1:0] x_prod;
  logic signed [PW-1:0] y_prod;
  logic signed [XW-1:0] x_sc;
  logic signed [XW-1:0] y_sc;

  // Remove the accumulated CORDIC gain from x and y
  always_comb begin
    x_prod = PW'(x_r) * PW'(KINV);
    y_prod = PW'(y_r) * PW'(KINV);
    x_sc   = XW'(x_prod >>> (W - 1));
    y_sc   = XW'(y_prod >>> (W - 1));
  end
`endif

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      i             <= '0;
      mode_r        <= 1'b0;
      x_r           <= '0;
      y_r           <= '0;
      z_r           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
      bus.z_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_r          <= XW'(bus.x_in);
            y_r          <= XW'(bus.y_in);
            z_r          <= bus.z_in;
            mode_r       <= bus.mode;
            i            <= '0;
            state        <= RUN;
            bus.in_ready <= 1'b0;
          end
        end
        RUN: begin
          if (i == IW'(LAST)) begin
            bus.x_out     <= x_r[W-1:0];
            bus.y_out     <= y_r[W-1:0];
            bus.z_out     <= z_r;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            if (i < IW'(ITER)) begin
              x_r <= x_nx;
              y_r <= y_nx;
              z_r <= z_nx;
            end
`ifdef CORDIC_GAIN_COMP_EN
            else begin
              x_r <= x_sc;
              y_r <= y_sc;
            end
`endif
            i <= i + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter.sv
// Scoreboard bench for cordic_iter (W=16, ITER=14), with expectations for
// both the gain-compensated and raw builds.
`timescale 1ns/1ps

module tb_cordic_iter;

  localparam int unsigned TW = 16;
  localparam int unsigned TI = 14;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = 16;
  localparam int R45  = 5793;
  localparam int R30X = 7094;
  localparam int R30Y = -4096;
  localparam int VX   = 5000;
`else
  localparam int LAT  = 15;
  localparam int R45  = 9539;
  localparam int R30X = 11683;
  localparam int R30Y = -6745;
  localparam int VX   = 8234;
`endif
  localparam int VZ  = 9672;
  localparam int TOL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    int ex;
    int ey;
    int ez;
    int acc;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];

  cordic_iter_if #(.W(TW)) bus ();

  cordic_iter #(.W(TW), .ITER(TI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp, input int tol);
    tests++;
    if ((act > exp + tol) || (act < exp - tol)) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (+/-%0d)", nm, act, exp, tol);
    end
  endtask

  // Monitor: pop and compare on every new result presentation
  initial begin : monitor
    logic  pv;
    exp_t  e;
    string nm;
    int    lat;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (bus.out_valid && !pv) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 1, 0, 0);
          end else begin
            e   = sb.pop_front();
            nm  = sb_name.pop_front();
            lat = cyc - e.acc;
            check({nm, "_x"}, int'(bus.x_out), e.ex, TOL);
            check({nm, "_y"}, int'(bus.y_out), e.ey, TOL);
            check({nm, "_z"}, int'(bus.z_out), e.ez, TOL);
            check({nm, "_latency"}, lat, LAT, 0);
          end
        end
        pv = bus.out_valid;
      end
    end
  end

  // Offer one operand, push its expectation on the accept edge
  task automatic send(input string nm, input logic m, input int x, input int y,
                      input int z, input int ex, input int ey, input int ez);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check({nm, "_in_ready_timeout"}, int'(bus.in_ready), 1, 0);
      return;
    end
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.x_in     = TW'(x);
    bus.y_in     = TW'(y);
    bus.z_in     = TW'(z);
    @(posedge clk);
    #1;
    e.ex  = ex;
    e.ey  = ey;
    e.ez  = ez;
    e.acc = cyc;
    sb.push_back(e);
    sb_name.push_back(nm);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) check({nm, "_out_valid_timeout"}, 0, 1, 0);
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check({nm, "_in_ready_timeout"}, 0, 1, 0);
  endtask

  initial begin : stim
    int cx, cy, cz, ov_seen, n;
    bus.in_valid  = 1'b0;
    bus.mode      = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.z_in      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready",  int'(bus.in_ready),  1, 0);
    check("reset_out_valid", int'(bus.out_valid), 0, 0);
    check("reset_x_out",     int'(bus.x_out),     0, 0);
    check("reset_y_out",     int'(bus.y_out),     0, 0);
    check("reset_z_out",     int'(bus.z_out),     0, 0);

    send("rot45", 1'b0, 8192, 0, 8192, R45, R45, 0);
    wait_valid("rot45");
    wait_ready("rot45");

    send("rotm30", 1'b0, 8192, 0, -5461, R30X, R30Y, 0);
    wait_valid("rotm30");
    wait_ready("rotm30");

    send("vec34", 1'b1, 3000, 4000, 0, VX, 0, VZ);
    wait_valid("vec34");
    wait_ready("vec34");

    // Backpressure: hold the result for 10 cycles, inject an ignored operand
    bus.out_ready = 1'b0;
    send("bp", 1'b0, 8192, 0, 8192, R45, R45, 0);
    wait_valid("bp");
    cx = int'(bus.x_out);
    cy = int'(bus.y_out);
    cz = int'(bus.z_out);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus.in_valid = 1'b1;
        bus.mode     = 1'b1;
        bus.x_in     = TW'(1000);
        bus.y_in     = TW'(-1000);
        bus.z_in     = TW'(100);
      end
      if (k == 3) bus.in_valid = 1'b0;
      check("bp_out_valid", int'(bus.out_valid), 1, 0);
      check("bp_in_ready",  int'(bus.in_ready),  0, 0);
      check("bp_x_hold",    int'(bus.x_out),     cx, 0);
      check("bp_y_hold",    int'(bus.y_out),     cy, 0);
      check("bp_z_hold",    int'(bus.z_out),     cz, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready",  int'(bus.in_ready),  1, 0);
    check("bp_release_out_valid", int'(bus.out_valid), 0, 0);
    check("idle_x_hold",          int'(bus.x_out),     R45, TOL);
    ov_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) ov_seen = 1;
    end
    check("bp_ignored_operand", ov_seen, 0, 0);

    // Reset during RUN, after five micro-rotations
    send("rst_run", 1'b0, 8192, 0, 8192, R45, R45, 0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0, 0);
    check("midrst_x_out",     int'(bus.x_out),     0, 0);
    check("midrst_y_out",     int'(bus.y_out),     0, 0);
    check("midrst_z_out",     int'(bus.z_out),     0, 0);
    sb.delete();
    sb_name.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_in_ready",  int'(bus.in_ready),  1, 0);
    check("postrst_out_valid", int'(bus.out_valid), 0, 0);

    send("after_rst", 1'b0, 8192, 0, -5461, R30X, R30Y, 0);
    wait_valid("after_rst");
    wait_ready("after_rst");

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cordic_iter.md
CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 SHALL have parameter W, default 32: data and angle width in bits, two's complement, legal range 12..32.
REQ-002 SHALL have parameter ITER, default 16: micro-rotations per operation, legal range 4..W-2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand offered.
REQ-006 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-007 SHALL have port mode, input, 1: 0 = rotation, 1 = vectoring; sampled on accept.
REQ-008 SHALL have ports x_in, y_in, z_in, input, W each: signed operands; z in binary angle units (2^(W-1) = pi rad).
REQ-009 SHALL have port out_valid, output, 1: result available.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-011 SHALL have ports x_out, y_out, z_out, output, W each: signed results, registered.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-013 SHALL accept an operand on an edge where in_valid && in_ready: load x, y, z, mode; clear the iteration counter i to 0; go to RUN.
REQ-014 SHALL ignore in_valid in RUN and DONE; operands change nothing.
REQ-015 SHALL keep internal x/y registers W+2 bits wide, sign-extended on load; z SHALL be W bits, wrapping modulo 2^W.
REQ-016 SHALL perform one micro-rotation per cycle in RUN with arithmetic right shift by i:
- rotation: d = +1 if z >= 0, else -1.
- vectoring: d = +1 if y < 0, else -1.
- update: x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i].
REQ-017 SHALL hold the constant table ATAN[i] = round(atan(2^-i) * 2^(W-1) / pi) for i = 0..ITER-1, generated from W (W=16: ATAN[0]=8192, ATAN[1]=4836).
REQ-018 SHALL leave RUN after the micro-rotation with i = ITER-1; the latency from the accept edge to out_valid high SHALL be ITER+1 cycles without gain compensation.
REQ-019 SHALL drive x_out/y_out from the low W bits of the internal x/y; the caller SHALL keep |x_in|, |y_in| <= 2^(W-2) so results fit.
REQ-020 SHALL hold x_out, y_out, z_out and out_valid stable in DONE until out_ready is high; on that edge it SHALL go to IDLE.
REQ-021 SHALL make in_ready high on the cycle after result consumption; there is no same-cycle accept from DONE.
REQ-022 SHALL keep the outputs unchanged in IDLE and RUN (last result visible, out_valid low).
REQ-023 SHALL produce z_out ~= atan2(y_in, x_in) in vectoring mode for x_in > 0, with y_out -> 0.

Reset
REQ-024 SHALL, on rst high (any state, including mid-RUN), force state IDLE, i = 0, internal registers 0, x_out/y_out/z_out = 0, out_valid = 0; the in-flight operation SHALL be discarded.
REQ-025 SHALL have in_ready = 1 on the first cycle after rst deasserts.

Configuration
REQ-026 SHALL honour macro CORDIC_GAIN_COMP_EN:
- Defined: one extra DONE-entry cycle multiplies x and y by KINV = round(0.607252935 * 2^(W-1)), arithmetic shift right W-1; latency ITER+2.
- Undefined: x/y carry the raw CORDIC gain (~1.64676); latency ITER+1; no multiplier is instantiated.

Verification (W=16, ITER=14, CORDIC_GAIN_COMP_EN defined unless stated; tolerance +/-4 LSB)
REQ-027 SHALL check rotation x=8192, y=0, z=8192 (45 deg) -> x_out=y_out=5793, z_out~0, out_valid exactly 16 cycles after accept.
REQ-028 SHALL check rotation x=8192, y=0, z=-5461 (-30 deg) -> x_out=7094, y_out=-4096; same vector with macro undefined -> x_out=11683, y_out=-6745 at 15 cycles.
REQ-029 SHALL check vectoring x=3000, y=4000 -> x_out=5000, y_out~0, z_out=9672.
REQ-030 SHALL check backpressure: out_ready low 10 cycles in DONE -> outputs and out_valid constant; a second in_valid pulse in that window is ignored; out_ready high -> in_ready high on the next cycle.
REQ-031 SHALL check reset mid-RUN: rst at iteration 5 -> all outputs 0, out_valid 0 immediately; the next accepted operand completes with the correct result.
